// File: rtl/byte_download_arbiter_if.sv
// Producer, consumer and status signals of the byte download arbiter, bundled
// so the arbiter and whoever drives it share one definition of the bus.
interface byte_download_arbiter_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              ready1_i;
    logic [DATA_W-1:0] byte1_i;
    logic              strobe1_i;
    logic              ready2_i;
    logic [DATA_W-1:0] byte2_i;
    logic              strobe2_i;
    logic [1:0]        grant_o;
    logic              out_valid_o;
    logic [DATA_W-1:0] out_data_o;
    logic              out_src_o;
    logic              out_ready_i;
    logic [LVL_W-1:0]  level_o;
    logic              overflow_o;
    logic              clear_ovf_i;

    // Arbiter side.
    modport slave (
        input  ready1_i, byte1_i, strobe1_i,
        input  ready2_i, byte2_i, strobe2_i,
        input  out_ready_i, clear_ovf_i,
        output grant_o, out_valid_o, out_data_o, out_src_o,
        output level_o, overflow_o
    );

    // Producers, consumer and control side.
    modport master (
        output ready1_i, byte1_i, strobe1_i,
        output ready2_i, byte2_i, strobe2_i,
        output out_ready_i, clear_ovf_i,
        input  grant_o, out_valid_o, out_data_o, out_src_o,
        input  level_o, overflow_o
    );
endinterface

// File: rtl/byte_download_arbiter.sv
// Two-channel byte download arbiter: round-robin grant with burst limit and
// idle timeout, feeding a show-ahead FIFO drained by a valid/ready consumer.
module byte_download_arbiter #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_BURST  = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    byte_download_arbiter_if.slave bus
);
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int IDLE_W  = $clog2(TIMEOUT + 1);

    localparam logic [LVL_W-1:0]   FULL_LVL  = LVL_W'(FIFO_DEPTH);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
    localparam logic [IDLE_W-1:0]  IDLE_MAX  = IDLE_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT1 = 2'd1,
        GRANT2 = 2'd2,
        GAP    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 last_q, last_d;       // 0: ch1 served last, 1: ch2
    logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 overflow_q, overflow_d;

    // Each entry carries its source channel above the data byte.
    logic [DATA_W:0]      mem_q [FIFO_DEPTH];

    logic                 full;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic                 sel_src;
    logic                 sel_ready;
    logic                 sel_strobe;
    logic                 other_ready;
    logic [DATA_W-1:0]    sel_byte;
    logic [DATA_W:0]      push_word;

    assign full = (level_q == FULL_LVL);
    assign pop  = (level_q != '0) && bus.out_ready_i;

    // Mux of the channel that currently owns the path (meaningful only in GRANTx).
    always_comb begin
        sel_src     = (state_q == GRANT2);
        sel_ready   = sel_src ? bus.ready2_i  : bus.ready1_i;
        sel_strobe  = sel_src ? bus.strobe2_i : bus.strobe1_i;
        sel_byte    = sel_src ? bus.byte2_i   : bus.byte1_i;
        other_ready = sel_src ? bus.ready1_i  : bus.ready2_i;
        push_word   = {sel_src, sel_byte};
    end

    // Arbitration FSM and the per-grant counters.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        push        = 1'b0;
        drop        = 1'b0;

        case (state_q)
            IDLE: begin
                if (!full) begin
                    if (bus.ready1_i && bus.ready2_i) begin
                        state_d = last_q ? GRANT1 : GRANT2;
                    end else if (bus.ready1_i) begin
                        state_d = GRANT1;
                    end else if (bus.ready2_i) begin
                        state_d = GRANT2;
                    end
                end
            end

            GRANT1, GRANT2: begin
                if (sel_strobe) begin
                    idle_cnt_d = '0;
                    // A pop in the same cycle frees the slot the push needs.
                    if (!full || pop) begin
                        push = 1'b1;
                        if (burst_cnt_q != BURST_MAX) begin
                            burst_cnt_d = burst_cnt_q + BURST_W'(1);
                        end
                    end else begin
                        drop = 1'b1;
                    end
                end else if (idle_cnt_q != IDLE_MAX) begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end

                // The strobe of the release cycle has already been handled above.
                if (!sel_ready ||
                    ((burst_cnt_q == BURST_MAX) && other_ready) ||
                    (idle_cnt_q == IDLE_MAX)) begin
                    state_d     = GAP;
                    last_d      = sel_src;
                    burst_cnt_d = '0;
                    idle_cnt_d  = '0;
                end
            end

            GAP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO bookkeeping and the sticky overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // A new drop wins over a clear in the same cycle.
        if (bus.clear_ovf_i) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            burst_cnt_q <= '0;
            idle_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage is not reset; level_q alone decides what is valid.
    always_ff @(posedge clk_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign bus.grant_o     = {state_q == GRANT2, state_q == GRANT1};
    assign bus.out_valid_o = (level_q != '0);
    assign bus.out_data_o  = mem_q[rd_ptr_q][DATA_W-1:0];
    assign bus.out_src_o   = mem_q[rd_ptr_q][DATA_W];
    assign bus.level_o     = level_q;
    assign bus.overflow_o  = overflow_q;
endmodule

// File: tb/tb_byte_download_arbiter.sv
// Directed and randomized checks of byte_download_arbiter against a queue-based
// reference model of the grant/FIFO rules.
module tb_byte_download_arbiter;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int MAXB  = 16;
    localparam int TMO   = 255;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    byte_download_arbiter_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus ();

    byte_download_arbiter #(
        .DATA_W(DW), .FIFO_DEPTH(DEPTH), .MAX_BURST(MAXB), .TIMEOUT(TMO)
    ) dut (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .bus          (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: who owns the path, bubble flag, fairness memory, counters, FIFO.
    int         m_owner;   // 0 none, 1 ch1, 2 ch2
    bit         m_gap;
    int         m_last;
    int         m_burst;
    int         m_quiet;
    bit         m_ovf;
    logic [8:0] m_fifo[$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_gap   = 1'b0;
        m_last  = 2;
        m_burst = 0;
        m_quiet = 0;
        m_ovf   = 1'b0;
        m_fifo.delete();
    endtask

    task automatic model_edge();
        bit         do_pop, full, push, drop, rel, rdy, stb, oth;
        logic [7:0] dat;
        int         src;
        do_pop = (m_fifo.size() != 0) && bus.out_ready_i;
        full   = (m_fifo.size() == DEPTH);
        push   = 1'b0;
        drop   = 1'b0;
        dat    = '0;
        src    = m_owner;
        if (m_owner == 0) begin
            if (m_gap) begin
                m_gap = 1'b0;
            end else if (!full) begin
                if (bus.ready1_i && bus.ready2_i) m_owner = (m_last == 1) ? 2 : 1;
                else if (bus.ready1_i) m_owner = 1;
                else if (bus.ready2_i) m_owner = 2;
            end
        end else begin
            rdy = (m_owner == 1) ? bus.ready1_i  : bus.ready2_i;
            oth = (m_owner == 1) ? bus.ready2_i  : bus.ready1_i;
            stb = (m_owner == 1) ? bus.strobe1_i : bus.strobe2_i;
            dat = (m_owner == 1) ? bus.byte1_i   : bus.byte2_i;
            rel = !rdy || (m_burst == MAXB && oth) || (m_quiet == TMO);
            if (stb) begin
                m_quiet = 0;
                if (!full || do_pop) begin
                    push = 1'b1;
                    if (m_burst < MAXB) m_burst++;
                end else begin
                    drop = 1'b1;
                end
            end else begin
                m_quiet++;
            end
            if (rel) begin
                m_last  = m_owner;
                m_owner = 0;
                m_gap   = 1'b1;
                m_burst = 0;
                m_quiet = 0;
            end
        end
        if (bus.clear_ovf_i) m_ovf = 1'b0;
        if (drop) m_ovf = 1'b1;
        if (do_pop) void'(m_fifo.pop_front());
        if (push) m_fifo.push_back({(src == 2) ? 1'b1 : 1'b0, dat});
    endtask

    task automatic compare();
        logic [1:0] exp_grant;
        exp_grant = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
        chk("grant", 16'(bus.grant_o), 16'(exp_grant));
        chk("level", 16'(bus.level_o), 16'(m_fifo.size()));
        chk("valid", 16'(bus.out_valid_o), 16'(m_fifo.size() != 0));
        chk("overflow", 16'(bus.overflow_o), 16'(m_ovf));
        if (m_fifo.size() != 0) begin
            chk("data", 16'(bus.out_data_o), 16'(m_fifo[0][7:0]));
            chk("src", 16'(bus.out_src_o), 16'(m_fifo[0][8]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic idle_inputs();
        bus.ready1_i    = 1'b0;
        bus.byte1_i     = '0;
        bus.strobe1_i   = 1'b0;
        bus.ready2_i    = 1'b0;
        bus.byte2_i     = '0;
        bus.strobe2_i   = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.clear_ovf_i = 1'b0;
    endtask

    // Asserts reset between edges and checks the outputs clear before any edge.
    task automatic do_reset();
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_grant", 16'(bus.grant_o), 16'h0);
        chk("rst_level", 16'(bus.level_o), 16'h0);
        chk("rst_valid", 16'(bus.out_valid_o), 16'h0);
        chk("rst_ovf", 16'(bus.overflow_o), 16'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int         n;
        bit         r1, r2;
        logic [7:0] a_bytes [3];

        model_reset();
        do_reset();

        // ch1 alone sends A1..A3 to an always-ready consumer.
        a_bytes[0] = 8'hA1; a_bytes[1] = 8'hA2; a_bytes[2] = 8'hA3;
        bus.out_ready_i = 1'b1;
        bus.ready1_i    = 1'b1;
        step();
        chk("A_grant", 16'(bus.grant_o), 16'h1);
        for (int i = 0; i < 3; i++) begin
            bus.strobe1_i = 1'b1;
            bus.byte1_i   = a_bytes[i];
            step();
            chk("A_data", 16'(bus.out_data_o), 16'(a_bytes[i]));
            chk("A_src", 16'(bus.out_src_o), 16'h0);
        end
        bus.strobe1_i = 1'b0;
        bus.ready1_i  = 1'b0;
        repeat (4) step();

        // Both ready: ch1 first, burst limit of 16, bubble, then ch2.
        do_reset();
        bus.out_ready_i = 1'b1;
        bus.ready1_i    = 1'b1;
        bus.ready2_i    = 1'b1;
        step();
        chk("B_first", 16'(bus.grant_o), 16'h1);
        for (int i = 0; i < MAXB; i++) begin
            bus.strobe1_i = 1'b1;
            bus.byte1_i   = 8'(8'h10 + i);
            step();
        end
        bus.strobe1_i = 1'b0;
        step();
        chk("B_gap", 16'(bus.grant_o), 16'h0);
        step();
        chk("B_idle", 16'(bus.grant_o), 16'h0);
        step();
        chk("B_second", 16'(bus.grant_o), 16'h2);
        bus.ready1_i = 1'b0;
        bus.ready2_i = 1'b0;
        repeat (4) step();

        // Stalled consumer, ch2 sends 9 bytes into an 8-deep FIFO.
        do_reset();
        bus.ready2_i = 1'b1;
        step();
        chk("C_grant", 16'(bus.grant_o), 16'h2);
        for (int i = 0; i < 9; i++) begin
            bus.strobe2_i = 1'b1;
            bus.byte2_i   = 8'(8'hC0 + i);
            step();
        end
        bus.strobe2_i = 1'b0;
        chk("C_level", 16'(bus.level_o), 16'h8);
        chk("C_ovf", 16'(bus.overflow_o), 16'h1);
        bus.ready2_i = 1'b0;
        bus.ready1_i = 1'b1;
        repeat (6) step();
        chk("C_blocked", 16'(bus.grant_o), 16'h0);
        bus.clear_ovf_i = 1'b1;
        step();
        bus.clear_ovf_i = 1'b0;
        chk("C_clear", 16'(bus.overflow_o), 16'h0);
        bus.ready1_i    = 1'b0;
        bus.out_ready_i = 1'b1;
        repeat (10) step();
        chk("C_drained", 16'(bus.out_valid_o), 16'h0);

        // Full FIFO: pop+strobe stores, clear+drop keeps the flag set.
        do_reset();
        bus.ready1_i = 1'b1;
        step();
        for (int i = 0; i < DEPTH; i++) begin
            bus.strobe1_i = 1'b1;
            bus.byte1_i   = 8'(8'h30 + i);
            step();
        end
        bus.byte1_i     = 8'hEE;
        bus.out_ready_i = 1'b1;
        step();
        chk("D_level", 16'(bus.level_o), 16'h8);
        chk("D_noovf", 16'(bus.overflow_o), 16'h0);
        bus.out_ready_i = 1'b0;
        bus.byte1_i     = 8'hEF;
        bus.clear_ovf_i = 1'b1;
        step();
        chk("D_setwins", 16'(bus.overflow_o), 16'h1);
        bus.clear_ovf_i = 1'b0;
        bus.strobe1_i   = 1'b0;
        bus.ready1_i    = 1'b0;
        repeat (3) step();

        // ch1 granted but silent: foreign strobe ignored, timeout releases.
        do_reset();
        bus.out_ready_i = 1'b1;
        bus.ready1_i    = 1'b1;
        step();
        n = 0;
        while (bus.grant_o == 2'b01 && n < 400) begin
            n++;
            bus.strobe2_i = (n == 3);
            bus.byte2_i   = 8'h55;
            step();
        end
        bus.strobe2_i = 1'b0;
        chk("E_timeout_len", 16'(n), 16'(TMO + 1));
        chk("E_no55", 16'(bus.level_o), 16'h0);
        bus.ready1_i = 1'b0;
        repeat (3) step();

        // Randomized traffic against the model, two consumer speeds.
        do_reset();
        r1 = 1'b0;
        r2 = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) r1 = ~r1;
            if ($urandom_range(0, 7) == 0) r2 = ~r2;
            bus.ready1_i    = r1;
            bus.ready2_i    = r2;
            bus.strobe1_i   = ($urandom_range(0, 2) == 0);
            bus.strobe2_i   = ($urandom_range(0, 2) == 0);
            bus.byte1_i     = 8'($urandom);
            bus.byte2_i     = 8'($urandom);
            bus.out_ready_i = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            bus.clear_ovf_i = ($urandom_range(0, 31) == 0);
            step();
        end
        idle_inputs();
        repeat (4) step();

        // Reset in the middle of a burst with 5 bytes buffered.
        do_reset();
        bus.ready1_i = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            bus.strobe1_i = 1'b1;
            bus.byte1_i   = 8'(8'h70 + i);
            step();
        end
        chk("G_level5", 16'(bus.level_o), 16'h5);
        do_reset();
        step();
        chk("G_after", 16'(bus.level_o), 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
